// File: rtl/rob.sv
// Reorder buffer: three-wide in-order dispatch, out-of-order completion,
// up to three in-order retirements per cycle from a circular entry array.
module rob #(
    parameter int ROB  = 5,
    parameter int ROBW = 32,
    parameter int PR   = 6,
    localparam int PKT_W = 2 * PR + 7
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [2:0][PKT_W-1:0]          rob_in,
    input  logic [2:0]                     tail_incre,
    input  logic [2:0]                     complete_valid,
    input  logic [2:0][ROB-1:0]            complete_entry,
    output logic [2:0][PKT_W-1:0]          retire_entry,
    output logic [2:0]                     struct_stall,
    output logic [ROBW-1:0][PKT_W-1:0]     rob_entries_display,
    output logic [ROB-1:0]                 head_display,
    output logic [ROB-1:0]                 tail_display,
    input  logic [ROBW-1:0][PKT_W-1:0]     rob_entries_debug
);

    typedef struct packed {
        logic          valid;
        logic [PR-1:0] t_new;
        logic [PR-1:0] t_old;
        logic [4:0]    arch_reg;
        logic          completed;
    } rob_entry_t;

    localparam logic [ROB:0] DEPTH = (ROB + 1)'(ROBW);

    rob_entry_t [ROBW-1:0] entries;
    logic [ROB-1:0]        head;
    logic [ROB-1:0]        tail;
    logic [ROB:0]          count;
    logic [ROB:0]          free;
    logic [1:0]            requested;
    logic [1:0]            accepted;
    logic [1:0]            retire_cnt;
    rob_entry_t [2:0]      head_slots;
    rob_entry_t [2:0]      alloc;
    logic [2:0]            retire_ok;

    // The debug port is intentionally inert; folding it keeps it connected.
    logic unused_debug;
    assign unused_debug = ^rob_entries_debug;

    assign rob_entries_display = entries;
    assign head_display        = head;
    assign tail_display        = tail;

    // NOTE: every signal assigned in this block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        free         = DEPTH - count;
        struct_stall = 3'b000;
        if (free == '0)
            struct_stall = 3'b111;
        else if (free == (ROB + 1)'(1))
            struct_stall = 3'b110;
        else if (free == (ROB + 1)'(2))
            struct_stall = 3'b100;

        requested = (tail_incre > 3'd3) ? 2'd3 : tail_incre[1:0];
        accepted  = ((ROB + 1)'(requested) > free) ? free[1:0] : requested;

        for (int i = 0; i < 3; i++) begin
            alloc[i]       = rob_in[i];
            alloc[i].valid = 1'b1;
        end
    end

    // Retirement looks only at registered state, so a completion written at
    // this edge can retire at the earliest one cycle later.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            head_slots[i] = entries[head + ROB'(i)];
            retire_ok[i]  = head_slots[i].valid && head_slots[i].completed;
        end

        if (!retire_ok[0])
            retire_cnt = 2'd0;
        else if (!retire_ok[1])
            retire_cnt = 2'd1;
        else if (!retire_ok[2])
            retire_cnt = 2'd2;
        else
            retire_cnt = 2'd3;

        for (int i = 0; i < 3; i++)
            retire_entry[i] = (i < int'(retire_cnt)) ? head_slots[i] : '0;
    end

    // Write order matters: completion, then retirement clear, then dispatch.
    // Dispatch only ever targets slots that were empty at the start of the cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            // NOTE: the entry array is reset explicitly because an empty slot
            // must read as all zeros for the valid-bit occupancy tests.
            entries <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (complete_valid[i] && entries[complete_entry[i]].valid)
                    entries[complete_entry[i]].completed <= 1'b1;
            end
            for (int i = 0; i < 3; i++) begin
                if (i < int'(retire_cnt))
                    entries[head + ROB'(i)] <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                if (i < int'(accepted))
                    entries[tail + ROB'(i)] <= alloc[i];
            end
            head  <= head + ROB'(retire_cnt);
            tail  <= tail + ROB'(accepted);
            count <= count + (ROB + 1)'(accepted) - (ROB + 1)'(retire_cnt);
        end
    end

endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: dispatched packets are queued in program order and
// matched against every retire_entry slot that the DUT presents.
module tb_rob;

    localparam int ROB   = 5;
    localparam int ROBW  = 32;
    localparam int PR    = 6;
    localparam int PKT_W = 2 * PR + 7;

    logic                       clock;
    logic                       reset;
    logic [2:0][PKT_W-1:0]      rob_in;
    logic [2:0]                 tail_incre;
    logic [2:0]                 complete_valid;
    logic [2:0][ROB-1:0]        complete_entry;
    logic [2:0][PKT_W-1:0]      retire_entry;
    logic [2:0]                 struct_stall;
    logic [ROBW-1:0][PKT_W-1:0] rob_entries_display;
    logic [ROB-1:0]             head_display;
    logic [ROB-1:0]             tail_display;
    logic [ROBW-1:0][PKT_W-1:0] rob_entries_debug;

    rob #(.ROB(ROB), .ROBW(ROBW), .PR(PR)) dut (
        .clock               (clock),
        .reset               (reset),
        .rob_in              (rob_in),
        .tail_incre          (tail_incre),
        .complete_valid      (complete_valid),
        .complete_entry      (complete_entry),
        .retire_entry        (retire_entry),
        .struct_stall        (struct_stall),
        .rob_entries_display (rob_entries_display),
        .head_display        (head_display),
        .tail_display        (tail_display),
        .rob_entries_debug   (rob_entries_debug)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    logic [PKT_W-1:0] exp_q[$];

    // Packet fields, MSB first: valid, t_new, t_old, arch_reg, completed.
    localparam logic [PKT_W-1:0] P0  = {1'b1, 6'd4, 6'd5, 5'd1, 1'b0};
    localparam logic [PKT_W-1:0] P1  = {1'b1, 6'd5, 6'd6, 5'd2, 1'b1};
    localparam logic [PKT_W-1:0] P2  = {1'b1, 6'd1, 6'd2, 5'd3, 1'b0};
    localparam logic [PKT_W-1:0] R0  = {1'b1, 6'd4, 6'd5, 5'd1, 1'b1};
    localparam logic [PKT_W-1:0] R1  = {1'b1, 6'd5, 6'd6, 5'd2, 1'b1};
    localparam logic [PKT_W-1:0] R2  = {1'b1, 6'd1, 6'd2, 5'd3, 1'b1};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Model of acceptance: min(request, 3, free), with free taken from the
    // number of dispatched-but-unretired packets still in the queue.
    task automatic dispatch(input int n);
        int acc;
        logic [PKT_W-1:0] pkt;
        acc = (n > 3) ? 3 : n;
        if (acc > ROBW - exp_q.size())
            acc = ROBW - exp_q.size();
        for (int i = 0; i < acc; i++) begin
            pkt = rob_in[i];
            exp_q.push_back({1'b1, pkt[PKT_W-2:1], 1'b1});
        end
        tail_incre = 3'(n);
    endtask

    task automatic check_empty(input string tag);
        for (int i = 0; i < ROBW; i++)
            check(tag, rob_entries_display[i], 0);
        for (int i = 0; i < 3; i++)
            check({tag, "_retire"}, retire_entry[i], 0);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (n < 60 && !(head_display == tail_display &&
                           rob_entries_display[head_display][PKT_W-1] == 1'b0)) begin
            tick();
            n++;
        end
        check({tag, "_drained_in_budget"}, (n < 60), 1);
    endtask

    // Retirement monitor, sampled on the falling edge while state is stable.
    always @(negedge clock) begin
        logic gap;
        logic [PKT_W-1:0] exp;
        if (!reset) begin
            gap = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (retire_entry[i][PKT_W-1] === 1'b1) begin
                    check("retire_contiguous", gap, 0);
                    if (exp_q.size() == 0) begin
                        check("retire_unexpected", retire_entry[i], 0);
                    end else begin
                        exp = exp_q.pop_front();
                        check("retire_order", retire_entry[i], exp);
                    end
                end else begin
                    gap = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with dispatch and completion active: both must be ignored.
        reset             = 1'b1;
        rob_in[0]         = P0;
        rob_in[1]         = P1;
        rob_in[2]         = P2;
        tail_incre        = 3'd3;
        complete_valid    = 3'b111;
        complete_entry    = '0;
        rob_entries_debug = '1;
        tick();
        tick();
        reset          = 1'b0;
        tail_incre     = 3'd0;
        complete_valid = 3'b000;
        check("reset_head", head_display, 0);
        check("reset_tail", tail_display, 0);
        check("reset_stall", struct_stall, 3'b000);
        check_empty("reset_entry");
        tick();
        check("idle_head", head_display, 0);
        check("idle_tail", tail_display, 0);
        check("idle_stall", struct_stall, 3'b000);

        // Fill: three per cycle until two slots remain, then two, then none.
        for (int c = 1; c <= 12; c++) begin
            dispatch(3);
            tick();
            if (c == 10) begin
                check("fill10_tail", tail_display, 30);
                check("fill10_stall", struct_stall, 3'b100);
            end else if (c == 11) begin
                check("fill11_tail", tail_display, 0);
                check("fill11_stall", struct_stall, 3'b111);
            end else if (c == 12) begin
                check("fill12_tail", tail_display, 0);
                check("fill12_stall", struct_stall, 3'b111);
                check("fill12_head", head_display, 0);
            end
        end
        tail_incre = 3'd0;
        check("fill_entry0", rob_entries_display[0], P0);
        check("fill_entry29", rob_entries_display[29], P2);
        check("fill_entry30", rob_entries_display[30], P0);
        check("fill_entry31", rob_entries_display[31], P1);
        check("fill_no_retire", retire_entry[0], 0);

        // Complete entry 0: no same-cycle retire, then entries 0 and 1 retire.
        complete_valid    = 3'b001;
        complete_entry[0] = 5'd0;
        check("cmp0_same_cycle", retire_entry[0], 0);
        tick();
        complete_valid = 3'b000;
        check("cmp0_completed", rob_entries_display[0][0], 1);
        check("cmp0_retire0", retire_entry[0], R0);
        check("cmp0_retire1", retire_entry[1], R1);
        check("cmp0_retire2", retire_entry[2], 0);
        tick();
        check("cmp0_head", head_display, 2);
        check("cmp0_stall", struct_stall, 3'b100);
        check("cmp0_cleared", rob_entries_display[0], 0);

        // Ways 0 and 1 strobed; way 2 names entry 5 but is not strobed.
        complete_valid    = 3'b011;
        complete_entry[0] = 5'd2;
        complete_entry[1] = 5'd3;
        complete_entry[2] = 5'd5;
        tick();
        complete_valid = 3'b000;
        check("mask_entry2", rob_entries_display[2], R2);
        check("mask_entry3", rob_entries_display[3], R0);
        check("mask_entry5", rob_entries_display[5], P2);
        check("mask_retire2", retire_entry[2], R1);
        tick();
        check("mask_head", head_display, 5);

        // Complete everything left; drain wraps head from 31 back to 0.
        for (int idx = 5; idx < ROBW; idx += 3) begin
            complete_valid    = 3'b111;
            complete_entry[0] = ROB'(idx);
            complete_entry[1] = ROB'(idx + 1);
            complete_entry[2] = ROB'(idx + 2);
            tick();
        end
        complete_valid = 3'b000;
        drain("drain1");
        check("drain1_head", head_display, 0);
        check("drain1_tail", tail_display, 0);
        check("drain1_stall", struct_stall, 3'b000);
        check("drain1_queue", exp_q.size(), 0);
        check_empty("drain1_entry");

        // Fresh dispatch: way 1 is completed but must wait behind the head.
        dispatch(3);
        tick();
        tail_incre = 3'd0;
        check("redisp_tail", tail_display, 3);
        check("redisp_valid0", rob_entries_display[0][PKT_W-1], 1);
        check("redisp_valid2", rob_entries_display[2][PKT_W-1], 1);
        check("redisp_blocked", retire_entry[0], 0);

        // Dispatch and head completion in the same cycle.
        dispatch(3);
        complete_valid    = 3'b001;
        complete_entry[0] = 5'd0;
        tick();
        tail_incre     = 3'd0;
        complete_valid = 3'b000;
        check("concur_tail", tail_display, 6);
        check("concur_retire0", retire_entry[0], R0);
        check("concur_retire1", retire_entry[1], R1);
        check("concur_retire2", retire_entry[2], 0);

        // Completion alongside retirement, then drain.
        complete_valid    = 3'b111;
        complete_entry[0] = 5'd2;
        complete_entry[1] = 5'd3;
        complete_entry[2] = 5'd5;
        tick();
        complete_valid = 3'b000;
        drain("drain2");
        check("drain2_head", head_display, 6);
        check("drain2_tail", tail_display, 6);
        check("drain2_stall", struct_stall, 3'b000);
        check("drain2_queue", exp_q.size(), 0);

        // Reset mid-operation discards live entries.
        dispatch(3);
        tick();
        check("pre_reset_tail", tail_display, 9);
        reset             = 1'b1;
        tail_incre        = 3'd3;
        complete_valid    = 3'b001;
        complete_entry[0] = 5'd6;
        tick();
        exp_q.delete();
        reset          = 1'b0;
        tail_incre     = 3'd0;
        complete_valid = 3'b000;
        check("midrst_head", head_display, 0);
        check("midrst_tail", tail_display, 0);
        check("midrst_stall", struct_stall, 3'b000);
        check_empty("midrst_entry");
        tick();
        check("midrst_next_retire", retire_entry[0], 0);
        check("midrst_next_tail", tail_display, 0);
        check("final_queue", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rob.md
ROB -- requirements
Module: rob

Interface
REQ-001 Parameter ROB, default 5, index width of an entry/pointer.
REQ-002 Parameter ROBW, default 32 (2**ROB), number of entries.
REQ-003 Parameter PR, default 6, physical register tag width.
REQ-004 Packet ROB_ENTRY_PACKET SHALL hold, in order: valid (1b), Tnew (PR), Told (PR), arch_reg (5b), completed (1b).
REQ-005 clock  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 rob_in  input  3 x packet  dispatch packets; way 0 oldest.
REQ-008 tail_incre  input  3  requested allocations this cycle (0-3), taken from way 0 upward.
REQ-009 complete_valid  input  3  per-way completion strobe, bitmask.
REQ-010 complete_entry  input  3 x ROB  entry index completed per way.
REQ-011 retire_entry  output  3 x packet  entries retiring this cycle; way 0 oldest.
REQ-012 struct_stall  output  3  per-way "no space" mask for dispatch.
REQ-013 rob_entries_display  output  ROBW x packet  current entry array.
REQ-014 head_display  output  ROB  current head pointer.
REQ-015 tail_display  output  ROB  current tail pointer.
REQ-016 rob_entries_debug  input  ROBW x packet  debug port; SHALL have no functional effect.

Function
REQ-017 Circular buffer; head = oldest entry, tail = next free slot; both wrap modulo ROBW.
REQ-018 An occupancy counter (0..ROBW) SHALL distinguish full from empty when head == tail.
REQ-019 free = ROBW - count, from registered state only.
REQ-020 struct_stall (combinational): free>=3 -> 000; free==2 -> 100; free==1 -> 110; free==0 -> 111.
REQ-021 accepted = min(tail_incre, free); rob_in[i] for i < accepted written to entry (tail+i) mod ROBW at the clock edge, valid forced to 1, other fields copied (including completed).
REQ-022 Ways i >= accepted SHALL be dropped silently; tail advances by accepted.
REQ-023 Completion: at clock edge, for each way with complete_valid[i]=1 and target entry valid, set that entry's completed=1; strobes to invalid entries ignored; duplicate indices harmless.
REQ-024 Retirement (combinational from registered state): retire count r = number of consecutive entries from head, up to 3, with valid=1 and completed=1; stops at first non-completed/invalid entry.
REQ-025 retire_entry[i] = entry (head+i) for i < r; retire_entry[i] = all zeros for i >= r.
REQ-026 At clock edge retired entries SHALL be cleared to zero and head advances by r.
REQ-027 count_next = count + accepted - r; free for dispatch ignores same-cycle retirement.
REQ-028 A completion arriving in cycle N SHALL make the entry retire-eligible no earlier than cycle N+1.
REQ-029 Dispatch into slots freed by same-cycle retirement SHALL NOT occur; a slot is allocated only if empty at the start of the cycle.
REQ-030 Dispatch, completion and retirement in the same cycle SHALL all take effect independently.

Reset
REQ-031 On reset: all entries zero, head=0, tail=0, count=0; struct_stall=000; retire_entry all zero; completion/dispatch inputs ignored that cycle.
REQ-032 Reset mid-operation discards all entries with no retire output in the following cycle.

Verification
REQ-033 After reset, no inputs -> head=0, tail=0, struct_stall=000, all entries/retire_entry zero.
REQ-034 rob_in = {(1,4,5,1,0),(1,5,6,2,1),(1,1,2,3,0)}, tail_incre=3 held 12 cycles -> tail 3,6,...,30 after 10 edges, stall=100; 11th edge accepts 2, tail=0, stall=111; 12th edge no change; nothing retires (entry 0 not completed).
REQ-035 Full ROB, complete_valid=001, complete_entry[0]=0 -> next cycle entry 0 completed; following cycle retire_entry = entries 0,1 (entry 2 not completed), head=2, count=30, stall=100.
REQ-036 complete_valid=011 with complete_entry={2,3,5} -> entries 2 and 3 completed, entry 5 untouched (way 2 not strobed).
REQ-037 Complete all non-completed entries -> 3 retire per cycle in order until empty; head wraps 31->0; final head=tail, count=0, stall=000.
REQ-038 After draining, dispatch 3 with tail_incre=3 for one cycle -> entries at tail..tail+2 valid, tail advances by 3, way 1 entry retires the cycle after only if it is at head (i.e., head entry completed first).
